uart_tx_arbiter: RTL and testbench

//  Shares one uart_transmitter_fsm among NUM_REQ byte sources using round-robin arbitration.

---
 rtl/uart_arb_pkg.sv | 22 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 45 ++++
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// The optional burst lock is enabled by defining UART_ARB_LOCK_EN.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        LOCKED    = 2'd2
    } arb_state_t;

    localparam int NUM_REQ_DEF   = 4;
    localparam int DATA_BITS_DEF = 8;

    // Wrap is an explicit compare so non-power-of-two counts stay in range.
    function automatic int next_idx(input int idx, input int n);
        if (idx == n - 1) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first valid index at or after ptr, wrapping to the
// lowest valid index when nothing at or above ptr is valid.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               any_valid_o,
    output logic [IDX_W-1:0]   win_o
);

    logic masked_found;
    logic any_found;
    logic [IDX_W-1:0] masked_win;
    logic [IDX_W-1:0] plain_win;

    always_comb begin
        masked_found = 1'b0;
        masked_win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!masked_found && valid_i[i] && (i >= int'(ptr_i))) begin
                masked_found = 1'b1;
                masked_win   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        any_found = 1'b0;
        plain_win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_found && valid_i[i]) begin
                any_found = 1'b1;
                plain_win = IDX_W'(i);
            end
        end
    end

    assign any_valid_o = any_found;
    assign win_o       = masked_found ? masked_win : plain_win;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Define UART_ARB_LOCK_EN to keep multi-byte bursts (ended by req_last) together.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_start,
    output logic [DATA_BITS-1:0]         tx_data,
    input  logic                         tx_done,
    output logic [IDX_W-1:0]             grant_id,
    output logic                         busy,
    output logic [1:0]                   dbg_state_o
);

    // Handshake: a requester's byte is taken in the single cycle its req_ready
    // is high; req_valid may drop at any time before that with no side effect.

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [DATA_BITS-1:0]   tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
    logic                   tx_start_q, tx_start_d;
    logic                   busy_q, busy_d;

    logic                   any_valid;
    logic [IDX_W-1:0]       win;
    logic                   accept;
    logic [IDX_W-1:0]       sel;
    logic                   release_lock;
    logic [IDX_W-1:0]       ptr_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid_i     (req_valid),
        .ptr_i       (ptr_q),
        .any_valid_o (any_valid),
        .win_o       (win)
    );

    assign ptr_next = IDX_W'(next_idx(int'(grant_q), NUM_REQ));

`ifdef UART_ARB_LOCK_EN
    logic last_q, last_d;

    // While locked only the owner may send; its index is already in grant_q.
    assign accept       = ((state_q == IDLE) && any_valid) ||
                          ((state_q == LOCKED) && req_valid[grant_q]);
    assign sel          = (state_q == LOCKED) ? grant_q : win;
    assign release_lock = last_q;
`else
    logic unused_last;

    assign unused_last  = ^req_last;
    assign accept       = (state_q == IDLE) && any_valid;
    assign sel          = win;
    assign release_lock = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            tx_data_q   <= '0;
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            last_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            tx_data_q   <= tx_data_d;
            req_ready_q <= req_ready_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
`ifdef UART_ARB_LOCK_EN
            last_q      <= last_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_d = release_lock ? IDLE : LOCKED;
                end
            end
            LOCKED: begin
                if (accept) begin
                    state_d = WAIT_DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_start_d  = 1'b0;
        req_ready_d = '0;
        tx_data_d   = tx_data_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        ptr_d       = ptr_q;
`ifdef UART_ARB_LOCK_EN
        last_d      = last_q;
`endif
        if (accept) begin
            tx_start_d       = 1'b1;
            req_ready_d[sel] = 1'b1;
            tx_data_d        = req_data[int'(sel)*DATA_BITS +: DATA_BITS];
            grant_d          = sel;
            busy_d           = 1'b1;
`ifdef UART_ARB_LOCK_EN
            last_d           = req_last[sel];
`endif
        end else if ((state_q == WAIT_DONE) && tx_done) begin
            busy_d = 1'b0;
            // A held lock keeps the pointer so the owner is not rotated away.
            if (release_lock) begin
                ptr_d = ptr_next;
            end
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: transaction table plus hand-written
// sequences for spurious tx_done, WAIT_DONE input noise and mid-op reset.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N*DB-1:0] req_data;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic          tx_start;
    logic [DB-1:0] tx_data;
    logic          tx_done;
    logic [1:0]    grant_id;
    logic          busy;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] last;
        int           exp_grant;
        logic [7:0]   exp_data;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        while (!tx_start && lat < 12) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_txn(input logic [7:0] exp_data);
        repeat (19) tick();
        check("hold_data", tx_data, exp_data);
        check("hold_busy", busy, 1);
        tx_done = 1'b1;
        check("busy_in_done_cycle", busy, 1);
        tick();
        tx_done = 1'b0;
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        int lat;
        logic [7:0] last_data;

        vecs[0]  = '{4'b1111, 4'b1111, 0, 8'h41};
        vecs[1]  = '{4'b1111, 4'b1111, 1, 8'h42};
        vecs[2]  = '{4'b1111, 4'b1111, 2, 8'h43};
        vecs[3]  = '{4'b1111, 4'b1111, 3, 8'h44};
        vecs[4]  = '{4'b1111, 4'b1111, 0, 8'h41};
        vecs[5]  = '{4'b0100, 4'b1111, 2, 8'h43};
        vecs[6]  = '{4'b0010, 4'b1111, 1, 8'h42};
        vecs[7]  = '{4'b0101, 4'b1111, 2, 8'h43};
        vecs[8]  = '{4'b0101, 4'b1111, 0, 8'h41};
        vecs[9]  = '{4'b0010, 4'b1111, 1, 8'h42};
        vecs[10] = '{4'b0010, 4'b1111, 1, 8'h42};
`ifdef UART_ARB_LOCK_EN
        vecs[11] = '{4'b0101, 4'b1011, 2, 8'h43};
        vecs[12] = '{4'b0101, 4'b1011, 2, 8'h43};
        vecs[13] = '{4'b0101, 4'b1111, 2, 8'h43};
        vecs[14] = '{4'b0001, 4'b1111, 0, 8'h41};
`else
        vecs[11] = '{4'b0101, 4'b1011, 2, 8'h43};
        vecs[12] = '{4'b0101, 4'b1011, 0, 8'h41};
        vecs[13] = '{4'b0100, 4'b1011, 2, 8'h43};
        vecs[14] = '{4'b0100, 4'b1111, 2, 8'h43};
`endif

        rst_n     = 1'b0;
        req_valid = '1;
        req_last  = '1;
        req_data  = {8'h44, 8'h43, 8'h42, 8'h41};
        tx_done   = 1'b0;
        repeat (3) tick();
        check("rst_ready", req_ready, 0);
        check("rst_start", tx_start, 0);
        check("rst_data", tx_data, 0);
        check("rst_grant", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            req_valid = vecs[i].valid;
            req_last  = vecs[i].last;
            wait_start(lat);
            check($sformatf("v%0d_latency", i), lat, 1);
            check($sformatf("v%0d_grant", i), grant_id, vecs[i].exp_grant);
            check($sformatf("v%0d_data", i), tx_data, vecs[i].exp_data);
            check($sformatf("v%0d_ready", i), req_ready, 1 << vecs[i].exp_grant);
            check($sformatf("v%0d_busy", i), busy, 1);
            tick();
            req_valid = '0;
            check($sformatf("v%0d_start_pulse", i), tx_start, 0);
            check($sformatf("v%0d_ready_pulse", i), req_ready, 0);
            finish_txn(vecs[i].exp_data);
        end
        last_data = vecs[NV-1].exp_data;

        // Spurious tx_done while idle must not disturb anything.
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (3) tick();
        check("spur_start", tx_start, 0);
        check("spur_ready", req_ready, 0);
        check("spur_data", tx_data, last_data);
        check("spur_state", dbg_state, 0);

        // Requester 0 wins; other valids toggling during WAIT_DONE are ignored.
        req_valid = 4'b0001;
        wait_start(lat);
        check("noise_latency", lat, 1);
        check("noise_grant", grant_id, 0);
        check("noise_data", tx_data, 8'h41);
        for (int k = 0; k < 6; k++) begin
            tick();
            req_valid = 4'($urandom_range(0, 15));
            check($sformatf("noise_start_%0d", k), tx_start, 0);
            check($sformatf("noise_ready_%0d", k), req_ready, 0);
            check($sformatf("noise_hold_%0d", k), tx_data, 8'h41);
        end
        req_valid = '0;
        finish_txn(8'h41);

        // Reset mid-transmission; ptr is 1 here, so a post-reset grant of 0 shows it was cleared.
        tick();
        req_valid = 4'b1000;
        wait_start(lat);
        check("mid_grant", grant_id, 3);
        req_valid = '0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_state", dbg_state, 0);
        check("mid_data", tx_data, 0);
        tick();
        tick();
        req_valid = 4'b1111;
        rst_n = 1'b1;
        wait_start(lat);
        check("post_rst_latency", lat, 1);
        check("post_rst_grant", grant_id, 0);
        check("post_rst_data", tx_data, 8'h41);
        req_valid = '0;
        finish_txn(8'h41);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
